// File: rtl/mem_responder.sv
// Memory-side responder for PE pointer reads: queues request packets, reads the
// filter or ifmap SRAM and returns one data packet per request to the source node.
module mem_responder #(
    parameter int WIDTH            = 4,
    parameter int VALID_DATA_WIDTH = 8,
    parameter int DATA_WIDTH       = 2*WIDTH + 2 + VALID_DATA_WIDTH,
    parameter int FILTER_DEPTH     = 25,
    parameter int IFMAP_DEPTH      = 49,
    parameter int FIFO_DEPTH       = 4,
    parameter int MY_INDEX         = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    input  logic                        load_en,
    input  logic                        load_sel,
    input  logic [VALID_DATA_WIDTH-1:0] load_addr,
    input  logic [VALID_DATA_WIDTH-1:0] load_data,
    output logic                        busy,
    output logic [15:0]                 req_count,
    output logic [7:0]                  err_count
);

    // state    | meaning
    // ST_IDLE  | waiting for a queued request; pops the FIFO head
    // ST_READ  | SRAM lookup, response word registered
    // ST_SEND  | response presented, held until out_ready
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    localparam int AW    = VALID_DATA_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FA_W  = $clog2(FILTER_DEPTH);
    localparam int IA_W  = $clog2(IFMAP_DEPTH);
    localparam int RW    = WIDTH + 2 + AW;

    localparam logic [AW-1:0]    FILT_LIM  = AW'(FILTER_DEPTH);
    localparam logic [AW-1:0]    IFM_LIM   = AW'(IFMAP_DEPTH);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [WIDTH-1:0] MY_ID     = WIDTH'(MY_INDEX);

    logic [AW-1:0] filter_mem [FILTER_DEPTH];
    logic [AW-1:0] ifmap_mem  [IFMAP_DEPTH];
    logic [RW-1:0] fifo_mem   [FIFO_DEPTH];

    logic [1:0]            state_q,     state_d;
    logic [PTR_W-1:0]      wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]      count_q,     count_d;
    logic [RW-1:0]         req_q,       req_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [15:0]           req_count_q, req_count_d;
    logic [7:0]            err_count_q, err_count_d;

    logic          push, pop;
    logic [RW-1:0] req_in;
    logic          dst_unused;
    logic [WIDTH-1:0] req_src;
    logic [1:0]    req_type;
    logic [AW-1:0] req_ptr;
    logic [AW-1:0] rd_word;
    logic          rd_err;

    // The destination field only routed the packet here; it is not stored.
    assign req_in     = {in_data[DATA_WIDTH-1 -: WIDTH], in_data[AW+1:0]};
    assign dst_unused = ^in_data[DATA_WIDTH-WIDTH-1 -: WIDTH];

    assign in_ready  = (count_q != FIFO_FULL);
    assign push      = in_valid && in_ready;
    assign pop       = (state_q == ST_IDLE) && (count_q != '0);
    assign out_valid = (state_q == ST_SEND);
    assign out_data  = out_data_q;
    assign busy      = (count_q != '0) || (state_q != ST_IDLE);
    assign req_count = req_count_q;
    assign err_count = err_count_q;

    assign req_src  = req_q[RW-1 -: WIDTH];
    assign req_type = req_q[AW+1:AW];
    assign req_ptr  = req_q[AW-1:0];

    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        case (req_type)
            2'd2: begin
                if (req_ptr < FILT_LIM) rd_word = filter_mem[req_ptr[FA_W-1:0]];
                else                    rd_err  = 1'b1;
            end
            2'd1: begin
                if (req_ptr < IFM_LIM) rd_word = ifmap_mem[req_ptr[IA_W-1:0]];
                else                   rd_err  = 1'b1;
            end
            default: rd_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        req_d       = req_q;
        out_data_d  = out_data_q;
        req_count_d = req_count_q;
        err_count_d = err_count_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            req_d    = fifo_mem[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: if (pop) state_d = ST_READ;
            ST_READ: begin
                out_data_d = {MY_ID, req_src, req_type, rd_word};
                if (rd_err && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    req_count_d = req_count_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            req_q       <= '0;
            out_data_q  <= '0;
            req_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            req_q       <= req_d;
            out_data_q  <= out_data_d;
            req_count_q <= req_count_d;
            err_count_q <= err_count_d;
        end
    end

    // Storage arrays carry no reset; the FIFO pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= req_in;
    end

    always_ff @(posedge clk) begin
        if (load_en) begin
            if (!load_sel && (load_addr < FILT_LIM))
                filter_mem[load_addr[FA_W-1:0]] <= load_data;
            if (load_sel && (load_addr < IFM_LIM))
                ifmap_mem[load_addr[IA_W-1:0]] <= load_data;
        end
    end

endmodule
